// File: rtl/csr_pkg.sv
// Shared CSR definitions: op encodings, counter address map, read-only test.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // Addresses with [11:10] == 2'b11 are architecturally read-only.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with split 32-bit half writes.
// A write to either half wins over the increment for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] value_q;
  logic [63:0] value_d;

  // Next value: half write has priority, otherwise wrap-around increment.
  always_comb begin
    value_d = value_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) value_d[31:0]  = wdata;
      if (wr_hi) value_d[63:32] = wdata;
    end else if (inc) begin
      value_d = value_q + 64'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/csr_unit_param.sv
// Machine-mode CSR unit: GP CSR bank, mcycle/minstret with user aliases,
// CSRRW/CSRRS/CSRRC with a single registered response per request.
module csr_unit_param
  import csr_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_GP  = 8,
  parameter logic [11:0] GP_BASE = 12'h340,
  parameter int unsigned CNT_W   = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_nowrite,
  input  logic            instret_inc,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal
);

  localparam int unsigned IDX_W = (NUM_GP > 1) ? $clog2(NUM_GP) : 1;

  csr_op_e           op;
  logic [11:0]       gp_off;
  logic [IDX_W-1:0]  gp_idx;
  logic              gp_hit;
  logic              mapped;
  logic [XLEN-1:0]   rd_val;
  logic [XLEN-1:0]   new_val;
  logic              active;
  logic              wants_write;
  logic              illegal;
  logic              we;
  logic [XLEN-1:0]   gp_q [NUM_GP];
  logic [CNT_W-1:0]  mcycle;
  logic [CNT_W-1:0]  minstret;
  logic              rsp_valid_q,   rsp_valid_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic [XLEN-1:0]   rsp_rdata_q,   rsp_rdata_d;

  assign op     = csr_op_e'(req_op);
  // Unsigned offset: addresses below GP_BASE wrap high and miss the bank.
  assign gp_off = req_addr - GP_BASE;
  assign gp_idx = gp_off[IDX_W-1:0];

  // Address decode and pre-write read value.
  always_comb begin
    gp_hit = 1'b0;
    mapped = 1'b0;
    rd_val = '0;
    if (gp_off < 12'(NUM_GP)) begin
      gp_hit = 1'b1;
      mapped = 1'b1;
      rd_val = gp_q[gp_idx];
    end
    case (req_addr)
      CSR_MCYCLE,    CSR_CYCLE:    begin mapped = 1'b1; rd_val = mcycle[XLEN-1:0];       end
      CSR_MCYCLEH,   CSR_CYCLEH:   begin mapped = 1'b1; rd_val = mcycle[CNT_W-1:XLEN];   end
      CSR_MINSTRET,  CSR_INSTRET:  begin mapped = 1'b1; rd_val = minstret[XLEN-1:0];     end
      CSR_MINSTRETH, CSR_INSTRETH: begin mapped = 1'b1; rd_val = minstret[CNT_W-1:XLEN]; end
      default: ;
    endcase
  end

  // Read-modify-write value, legality and write enable.
  always_comb begin
    new_val = rd_val;
    case (op)
      CSR_OP_RW: new_val = req_wdata;
      CSR_OP_RS: new_val = rd_val | req_wdata;
      CSR_OP_RC: new_val = rd_val & ~req_wdata;
      default:   new_val = rd_val;
    endcase
    active      = req_valid && (op != CSR_OP_NONE);
    wants_write = (op == CSR_OP_RW) ||
                  (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !req_nowrite);
    illegal     = active && (!mapped || (csr_is_ro(req_addr) && wants_write));
    we          = active && !illegal && wants_write;
  end

  // Response next-state: data only for legal, real ops.
  always_comb begin
    rsp_valid_d   = req_valid;
    rsp_illegal_d = illegal;
    rsp_rdata_d   = (active && !illegal) ? rd_val : '0;
  end

  // Response register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  // General-purpose CSR bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
    end else if (we && gp_hit) begin
      gp_q[gp_idx] <= new_val;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (1'b1),
    .wr_lo   (we && (req_addr == CSR_MCYCLE)),
    .wr_hi   (we && (req_addr == CSR_MCYCLEH)),
    .wdata   (new_val),
    .value   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (instret_inc),
    .wr_lo   (we && (req_addr == CSR_MINSTRET)),
    .wr_hi   (we && (req_addr == CSR_MINSTRETH)),
    .wdata   (new_val),
    .value   (minstret)
  );

  assign rsp_valid   = rsp_valid_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_csr_unit_param.sv
// Bench for csr_unit_param: directed scenarios plus random traffic, all
// checked against a behavioural model of the CSR file and counters.
module tb_csr_unit_param;

  localparam int unsigned NUM_GP  = 8;
  localparam logic [11:0] GP_BASE = 12'h340;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_nowrite;
  logic        instret_inc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  logic [31:0] m_gp [NUM_GP];
  logic [63:0] m_mc, m_mi;
  logic [31:0] last_rd;
  logic        last_ill;

  csr_unit_param #(
    .XLEN    (32),
    .NUM_GP  (NUM_GP),
    .GP_BASE (GP_BASE),
    .CNT_W   (64)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_nowrite (req_nowrite),
    .instret_inc (instret_inc),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_illegal (rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_GP; i++) m_gp[i] = '0;
    m_mc = '0;
    m_mi = '0;
  endtask

  // One clock of traffic; called at a falling edge, returns at the next one.
  task automatic step(input logic v, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic nw, input logic inc);
    logic        act, isgp, mapped, wr, ill;
    logic [31:0] old, nv, exp_rd;
    logic [63:0] n_mc, n_mi;
    int          gi, half;
    req_valid = v; req_op = op; req_addr = a; req_wdata = wd;
    req_nowrite = nw; instret_inc = inc;

    act    = v && (op != 2'd0);
    gi     = int'(a) - int'(GP_BASE);
    isgp   = (gi >= 0) && (gi < int'(NUM_GP));
    mapped = isgp;
    old    = isgp ? m_gp[gi] : 32'd0;
    half   = 0;
    case (a)
      12'hB00: begin mapped = 1; old = m_mc[31:0];  half = 1; end
      12'hB80: begin mapped = 1; old = m_mc[63:32]; half = 2; end
      12'hB02: begin mapped = 1; old = m_mi[31:0];  half = 3; end
      12'hB82: begin mapped = 1; old = m_mi[63:32]; half = 4; end
      12'hC00: begin mapped = 1; old = m_mc[31:0];  end
      12'hC80: begin mapped = 1; old = m_mc[63:32]; end
      12'hC02: begin mapped = 1; old = m_mi[31:0];  end
      12'hC82: begin mapped = 1; old = m_mi[63:32]; end
      default: ;
    endcase
    wr  = (op == 2'd1) || (op >= 2'd2 && !nw);
    ill = act && (!mapped || (a[11:10] == 2'b11 && wr));
    nv  = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
    exp_rd = (act && !ill) ? old : 32'd0;

    n_mc = m_mc + 64'd1;
    n_mi = m_mi + (inc ? 64'd1 : 64'd0);
    if (act && !ill && wr) begin
      if (isgp) m_gp[gi] = nv;
      case (half)
        1: n_mc = {m_mc[63:32], nv};
        2: n_mc = {nv, m_mc[31:0]};
        3: n_mi = {m_mi[63:32], nv};
        4: n_mi = {nv, m_mi[31:0]};
        default: ;
      endcase
    end

    @(posedge clk);
    #1;
    m_mc = n_mc;
    m_mi = n_mi;
    last_rd  = rsp_rdata;
    last_ill = rsp_illegal;
    chk("rsp_valid",   {31'd0, rsp_valid},   {31'd0, v});
    chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, ill});
    chk("rsp_rdata",   rsp_rdata,            exp_rd);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 12'h000, 32'd0, 1'b0, 1'b0);
  endtask

  logic [11:0] cnt_addrs [8] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'hC00, 12'hC80, 12'hC02, 12'hC82};

  initial begin
    logic [31:0] c0;
    logic [11:0] ra;
    reset_n = 1'b0; req_valid = 0; req_op = 0; req_addr = 0;
    req_wdata = 0; req_nowrite = 0; instret_inc = 0;
    model_reset();
    #1;
    chk("reset_valid", {31'd0, rsp_valid},   32'd0);
    chk("reset_rdata", rsp_rdata,            32'd0);
    chk("reset_ill",   {31'd0, rsp_illegal}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // RW then RS-nowrite read on GP entry 0.
    step(1, 2'd1, 12'h340, 32'hDEADBEEF, 0, 0);
    chk("rw340_old", last_rd, 32'd0);
    step(1, 2'd2, 12'h340, 32'd0, 1, 0);
    chk("rs340_rd", last_rd, 32'hDEADBEEF);

    // Set / clear on GP entry 1.
    step(1, 2'd1, 12'h341, 32'hF0, 0, 0);
    step(1, 2'd2, 12'h341, 32'h0F, 0, 0);
    chk("rs341_old", last_rd, 32'hF0);
    step(1, 2'd3, 12'h341, 32'h30, 0, 0);
    chk("rc341_old", last_rd, 32'hFF);
    step(1, 2'd2, 12'h341, 32'd0, 1, 0);
    chk("rc341_val", last_rd, 32'hCF);

    // Unmapped write, then read back every GP entry.
    step(1, 2'd1, GP_BASE + 12'(NUM_GP), 32'd1, 0, 0);
    chk("unmapped_ill", {31'd0, last_ill}, 32'd1);
    step(1, 2'd1, GP_BASE - 12'd1, 32'd1, 0, 0);
    for (int i = 0; i < NUM_GP; i++) step(1, 2'd2, GP_BASE + 12'(i), 32'd0, 1, 0);

    // Read-only alias: write illegal, read legal and tracks mcycle.
    step(1, 2'd1, 12'hC00, 32'd5, 0, 0);
    chk("c00_write_ill", {31'd0, last_ill}, 32'd1);
    step(1, 2'd3, 12'hC80, 32'd0, 1, 0);
    step(1, 2'd2, 12'hC00, 32'd0, 1, 0);
    c0 = last_rd;
    step(1, 2'd2, 12'hB00, 32'd0, 1, 0);
    chk("cycle_alias", last_rd, c0 + 32'd1);
    step(1, 2'd0, 12'h340, 32'hFFFF, 0, 0);

    // Counter wrap with write priority.
    step(1, 2'd1, 12'hB00, 32'hFFFFFFFF, 0, 0);
    step(1, 2'd1, 12'hB80, 32'hFFFFFFFF, 0, 0);
    step(1, 2'd2, 12'hB00, 32'd0, 1, 0);
    chk("wrap_lo_pre", last_rd, 32'hFFFFFFFF);
    step(1, 2'd2, 12'hB80, 32'd0, 1, 0);
    chk("wrap_hi_post", last_rd, 32'd0);
    step(1, 2'd2, 12'hC00, 32'd0, 1, 0);
    chk("wrap_lo_post", last_rd, 32'd1);

    // minstret burst interrupted by reset with a request in flight.
    for (int i = 0; i < 6; i++) step(1, 2'd2, 12'hB02, 32'd0, 1, 1);
    req_valid = 1; req_op = 2'd1; req_addr = 12'h340; req_wdata = 32'h1234;
    instret_inc = 1;
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_hold_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    req_valid = 0; instret_inc = 0;
    reset_n = 1'b1;
    step(1, 2'd2, 12'hB02, 32'd0, 1, 0);
    chk("minstret_after_rst", last_rd, 32'd0);
    step(1, 2'd2, 12'h340, 32'd0, 1, 1);
    chk("dropped_write", last_rd, 32'd0);
    step(1, 2'd2, 12'hC02, 32'd0, 1, 0);
    chk("minstret_resume", last_rd, 32'd1);
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0, 1: ra = GP_BASE + 12'($urandom_range(0, NUM_GP - 1));
        2:    ra = cnt_addrs[$urandom_range(0, 7)];
        3:    ra = ($urandom_range(0, 1) != 0) ? GP_BASE + 12'(NUM_GP) : GP_BASE - 12'd1;
        default: ra = 12'($urandom);
      endcase
      step(($urandom_range(0, 7) != 0), 2'($urandom), ra, $urandom,
           ($urandom_range(0, 2) == 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
